// File: rtl/binary_count_checker.sv
// binary_count_checker: locks onto a +1 (mod 2^WIDTH) count stream and flags breaks.
// Define BINARY_COUNT_CHECKER_FAST_RESYNC_EN to stay locked and resync on a mismatch.
module binary_count_checker #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     binary,
  input  logic                 valid,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error,
  output logic                 wrap,
  output logic [WIDTH-1:0]     expected,
  output logic [ERR_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQ,
    ST_LOCKED
  } state_e;

  localparam logic [7:0] LockTgt = 8'(LOCK_COUNT);

  state_e               state_q, state_d;
  logic [7:0]           run_q, run_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic                 locked_q, locked_d;
  logic                 error_q, error_d;
  logic                 wrap_q, wrap_d;
  logic [ERR_WIDTH-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] nxt;
  logic [7:0]       run_inc;
  logic             match;
  logic             bump;

  assign nxt     = binary + WIDTH'(1);
  assign run_inc = run_q + 8'd1;
  assign match   = (binary == exp_q);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    exp_d   = exp_q;
    error_d = 1'b0;
    wrap_d  = 1'b0;
    bump    = 1'b0;
    if (valid) begin
      unique case (state_q)
        ST_IDLE: begin
          exp_d   = nxt;
          run_d   = '0;
          state_d = ST_ACQ;
        end
        ST_ACQ: begin
          exp_d = nxt;
          if (match) begin
            run_d = run_inc;
            if (run_inc == LockTgt) state_d = ST_LOCKED;
          end else begin
            run_d = '0;
          end
        end
        ST_LOCKED: begin
          exp_d = nxt;
          if (match) begin
            wrap_d = (binary == '0);
          end else begin
            error_d = 1'b1;
            bump    = 1'b1;
`ifdef BINARY_COUNT_CHECKER_FAST_RESYNC_EN
            state_d = ST_LOCKED;
`else
            run_d   = '0;
            state_d = ST_ACQ;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A clear that collides with a new error keeps that error.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = bump ? ERR_WIDTH'(1) : '0;
    end else if (bump && !(&cnt_q)) begin
      cnt_d = cnt_q + ERR_WIDTH'(1);
    end
  end

  assign locked_d = (state_d == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      run_q    <= '0;
      exp_q    <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      wrap_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      exp_q    <= exp_d;
      locked_q <= locked_d;
      error_q  <= error_d;
      wrap_q   <= wrap_d;
      cnt_q    <= cnt_d;
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign wrap      = wrap_q;
  assign expected  = exp_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_binary_count_checker.sv
// tb_binary_count_checker: directed vectors, scoreboard queue, decoupled monitor.
// A second instance with ERR_WIDTH=2 shares the stimulus to cover saturation.
module tb_binary_count_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] binary = '0;
  logic       valid = 1'b0;
  logic       clear = 1'b0;

  logic       locked, error, wrap;
  logic [3:0] expected;
  logic [7:0] err_count;

  logic       locked2, error2, wrap2;
  logic [3:0] expected2;
  logic [1:0] err_count2;

  int checks = 0;
  int fails  = 0;

  logic [16:0] sb_q[$];

  always #5 clk = ~clk;

  binary_count_checker #(
    .WIDTH(4), .LOCK_COUNT(4), .ERR_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .binary(binary),
    .valid(valid), .clear(clear),
    .locked(locked), .error(error), .wrap(wrap),
    .expected(expected), .err_count(err_count)
  );

  binary_count_checker #(
    .WIDTH(4), .LOCK_COUNT(4), .ERR_WIDTH(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .binary(binary),
    .valid(valid), .clear(clear),
    .locked(locked2), .error(error2), .wrap(wrap2),
    .expected(expected2), .err_count(err_count2)
  );

  // r v c bin | locked error wrap expected err_count err_count(ERR_WIDTH=2)
  task automatic step(
    input logic r, input logic v, input logic c,
    input logic [3:0] b,
    input logic l, input logic e, input logic w,
    input logic [3:0] x, input logic [7:0] ec,
    input logic [1:0] ec2
  );
    @(negedge clk);
    reset  = r;
    valid  = v;
    clear  = c;
    binary = b;
    sb_q.push_back({l, e, w, x, ec, ec2});
  endtask

  initial begin : monitor
    logic [16:0] exp_v;
    logic [16:0] got_v;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        got_v = {locked, error, wrap, expected, err_count, err_count2};
        checks++;
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL out#%0d got L%b E%b W%b X%0d C%0d C2=%0d want L%b E%b W%b X%0d C%0d C2=%0d",
                   checks, got_v[16], got_v[15], got_v[14], got_v[13:10],
                   got_v[9:2], got_v[1:0], exp_v[16], exp_v[15], exp_v[14],
                   exp_v[13:10], exp_v[9:2], exp_v[1:0]);
        end
      end
    end
  end

  initial begin
    // reset
    step(1,0,0, 0, 0,0,0,  0, 0,0);
    // lock on 0..4
    step(0,1,0, 0, 0,0,0,  1, 0,0);
    step(0,1,0, 1, 0,0,0,  2, 0,0);
    step(0,1,0, 2, 0,0,0,  3, 0,0);
    step(0,1,0, 3, 0,0,0,  4, 0,0);
    step(0,1,0, 4, 1,0,0,  5, 0,0);
    // discontinuity 9, relock 10..13
    step(0,1,0, 9, 0,1,0, 10, 1,1);
    step(0,1,0,10, 0,0,0, 11, 1,1);
    step(0,1,0,11, 0,0,0, 12, 1,1);
    step(0,1,0,12, 0,0,0, 13, 1,1);
    step(0,1,0,13, 1,0,0, 14, 1,1);
    // wrap 14,15,0,1
    step(0,1,0,14, 1,0,0, 15, 1,1);
    step(0,1,0,15, 1,0,0,  0, 1,1);
    step(0,1,0, 0, 1,0,1,  1, 1,1);
    step(0,1,0, 1, 1,0,0,  2, 1,1);
    // valid low holds, clear alone zeroes
    step(0,0,0, 7, 1,0,0,  2, 1,1);
    step(0,0,1, 7, 1,0,0,  2, 0,0);
    // three mismatches, each followed by relock
    step(0,1,0, 8, 0,1,0,  9, 1,1);
    step(0,1,0, 9, 0,0,0, 10, 1,1);
    step(0,1,0,10, 0,0,0, 11, 1,1);
    step(0,1,0,11, 0,0,0, 12, 1,1);
    step(0,1,0,12, 1,0,0, 13, 1,1);
    step(0,1,0, 3, 0,1,0,  4, 2,2);
    step(0,1,0, 4, 0,0,0,  5, 2,2);
    step(0,1,0, 5, 0,0,0,  6, 2,2);
    step(0,1,0, 6, 0,0,0,  7, 2,2);
    step(0,1,0, 7, 1,0,0,  8, 2,2);
    step(0,1,0, 0, 0,1,0,  1, 3,3);
    step(0,1,0, 1, 0,0,0,  2, 3,3);
    step(0,1,0, 2, 0,0,0,  3, 3,3);
    step(0,1,0, 3, 0,0,0,  4, 3,3);
    step(0,1,0, 4, 1,0,0,  5, 3,3);
    // clear colliding with a locked mismatch
    step(0,1,1, 9, 0,1,0, 10, 1,1);
    step(0,1,0,10, 0,0,0, 11, 1,1);
    step(0,1,0,11, 0,0,0, 12, 1,1);
    step(0,1,0,12, 0,0,0, 13, 1,1);
    step(0,1,0,13, 1,0,0, 14, 1,1);
    step(0,1,0, 5, 0,1,0,  6, 2,2);
    step(0,1,0, 6, 0,0,0,  7, 2,2);
    step(0,1,0, 7, 0,0,0,  8, 2,2);
    step(0,1,0, 8, 0,0,0,  9, 2,2);
    step(0,1,0, 9, 1,0,0, 10, 2,2);
    step(0,1,0,15, 0,1,0,  0, 3,3);
    step(0,1,0, 0, 0,0,0,  1, 3,3);
    step(0,1,0, 1, 0,0,0,  2, 3,3);
    step(0,1,0, 2, 0,0,0,  3, 3,3);
    step(0,1,0, 3, 1,0,0,  4, 3,3);
    // saturation on the narrow counter
    step(0,1,0, 0, 0,1,0,  1, 4,3);
    // mismatch in ACQUIRE is silent
    step(0,1,0, 7, 0,0,0,  8, 4,3);
    step(0,1,0, 8, 0,0,0,  9, 4,3);
    step(0,1,0, 9, 0,0,0, 10, 4,3);
    step(0,1,0,10, 0,0,0, 11, 4,3);
    step(0,1,0,11, 1,0,0, 12, 4,3);
    // reset mid-operation overrides valid, relock takes 5 samples
    step(1,1,0,12, 0,0,0,  0, 0,0);
    step(0,1,0, 3, 0,0,0,  4, 0,0);
    step(0,1,0, 4, 0,0,0,  5, 0,0);
    step(0,1,0, 5, 0,0,0,  6, 0,0);
    step(0,1,0, 6, 0,0,0,  7, 0,0);
    step(0,1,0, 7, 1,0,0,  8, 0,0);
    // valid gaps do not change lock timing
    step(1,0,0, 0, 0,0,0,  0, 0,0);
    step(0,1,0, 0, 0,0,0,  1, 0,0);
    step(0,1,0, 1, 0,0,0,  2, 0,0);
    step(0,0,0, 9, 0,0,0,  2, 0,0);
    step(0,0,0, 9, 0,0,0,  2, 0,0);
    step(0,0,0, 9, 0,0,0,  2, 0,0);
    step(0,1,0, 2, 0,0,0,  3, 0,0);
    step(0,1,0, 3, 0,0,0,  4, 0,0);
    step(0,1,0, 4, 1,0,0,  5, 0,0);
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
